// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the 32-bit single-bus datapath.
// Define CU_DIV_EN to build the divide sequence (DWAIT state and reset_div).
module control_unit (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [31:0] ir,
  input  logic       con,
  input  logic       calc_finished,
  output logic       dp_clr,
  output logic [4:0] op_sel,
  output logic       R_out,
  output logic       MDR_out,
  output logic       PC_out,
  output logic       Zlo_out,
  output logic       Zhi_out,
  output logic       HI_out,
  output logic       LO_out,
  output logic       In_out,
  output logic       C_out,
  output logic       Rin,
  output logic       MDR_rd,
  output logic       MAR_rd,
  output logic       HI_rd,
  output logic       LO_rd,
  output logic       Zhi_rd,
  output logic       Zlo_rd,
  output logic       PC_rd,
  output logic       Out_rd,
  output logic       Y_rd,
  output logic       IR_rd,
  output logic       IncPC,
  output logic       Read,
  output logic       Write,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       BAout,
  output logic       CONin,
  output logic       reset_div,
  output logic       halted,
  output logic       illegal
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST,
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
`ifdef CU_DIV_EN
    S_DWAIT,
`endif
    S_HALT
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] opcode;

  assign opcode = ir[31:27];

  // Only the opcode field drives decode; the rest of IR belongs to the datapath.
  logic unused_inputs;
  assign unused_inputs = ^{ir[26:0], calc_finished};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; clr is sampled on the edge, not asynchronously.
  always_ff @(posedge clk) begin
    if (!clr) state_q <= S_RST;
    else      state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default before the case so that no
  // path through this block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    op_sel    = OP_ADD;
    dp_clr    = 1'b0;
    R_out     = 1'b0;
    MDR_out   = 1'b0;
    PC_out    = 1'b0;
    Zlo_out   = 1'b0;
    Zhi_out   = 1'b0;
    HI_out    = 1'b0;
    LO_out    = 1'b0;
    In_out    = 1'b0;
    C_out     = 1'b0;
    Rin       = 1'b0;
    MDR_rd    = 1'b0;
    MAR_rd    = 1'b0;
    HI_rd     = 1'b0;
    LO_rd     = 1'b0;
    Zhi_rd    = 1'b0;
    Zlo_rd    = 1'b0;
    PC_rd     = 1'b0;
    Out_rd    = 1'b0;
    Y_rd      = 1'b0;
    IR_rd     = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    BAout     = 1'b0;
    CONin     = 1'b0;
    reset_div = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_RST: begin
        dp_clr  = 1'b1;
        op_sel  = 5'b00000;
        state_d = S_T0;
      end

      S_T0: begin
        if (!run) begin
          op_sel = 5'b00000;
        end else begin
          PC_out  = 1'b1;
          MAR_rd  = 1'b1;
          IncPC   = 1'b1;
          state_d = S_T1;
        end
      end

      S_T1: begin
        Read    = 1'b1;
        MDR_rd  = 1'b1;
        state_d = S_T2;
      end

      S_T2: begin
        MDR_out = 1'b1;
        IR_rd   = 1'b1;
        state_d = S_T3;
      end

      S_T3: begin
        state_d = S_T0;
        case (opcode) inside
          [5'd3:5'd14]: begin
            Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1; state_d = S_T4;
          end
          OP_MUL: begin
            Gra = 1'b1; R_out = 1'b1; Y_rd = 1'b1; state_d = S_T4;
          end
`ifdef CU_DIV_EN
          OP_DIV: begin
            Gra = 1'b1; R_out = 1'b1; Y_rd = 1'b1; state_d = S_T4;
          end
`endif
          OP_LD, OP_LDI, OP_ST: begin
            Grb = 1'b1; BAout = 1'b1; Y_rd = 1'b1; state_d = S_T4;
          end
          OP_BR: begin
            Gra = 1'b1; R_out = 1'b1; CONin = 1'b1; state_d = S_T4;
          end
          OP_IN:   begin In_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; R_out = 1'b1; Out_rd = 1'b1; end
          OP_MFHI: begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_NOP:  ;
          OP_HALT: state_d = S_HALT;
          default: illegal = 1'b1;
        endcase
      end

      S_T4: begin
        state_d = S_T5;
        case (opcode) inside
          [5'd3:5'd14]: begin
            Grc = 1'b1; R_out = 1'b1; op_sel = opcode; Zlo_rd = 1'b1;
          end
          OP_MUL: begin
            Grb = 1'b1; R_out = 1'b1; op_sel = OP_MUL; Zhi_rd = 1'b1; Zlo_rd = 1'b1;
          end
`ifdef CU_DIV_EN
          OP_DIV: begin
            Grb = 1'b1; R_out = 1'b1; op_sel = OP_DIV; reset_div = 1'b1;
            state_d = S_DWAIT;
          end
`endif
          OP_LD, OP_LDI, OP_ST: begin C_out = 1'b1; Zlo_rd = 1'b1; end
          OP_BR:   begin PC_out = 1'b1; Y_rd = 1'b1; end
          default: state_d = S_T0;
        endcase
      end

`ifdef CU_DIV_EN
      // Divider operands stay on the bus until the divider reports completion.
      S_DWAIT: begin
        Grb    = 1'b1;
        R_out  = 1'b1;
        op_sel = OP_DIV;
        if (calc_finished) begin
          Zhi_rd  = 1'b1;
          Zlo_rd  = 1'b1;
          state_d = S_T5;
        end
      end
`endif

      S_T5: begin
        state_d = S_T6;
        case (opcode) inside
          [5'd3:5'd14], OP_LDI: begin
            Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; state_d = S_T0;
          end
          OP_MUL, OP_DIV: begin Zlo_out = 1'b1; LO_rd = 1'b1; end
          OP_LD, OP_ST:   begin Zlo_out = 1'b1; MAR_rd = 1'b1; end
          OP_BR:          begin C_out = 1'b1; Zlo_rd = 1'b1; end
          default:        state_d = S_T0;
        endcase
      end

      S_T6: begin
        state_d = S_T0;
        case (opcode)
          OP_MUL, OP_DIV: begin Zhi_out = 1'b1; HI_rd = 1'b1; end
          OP_LD: begin Read = 1'b1; MDR_rd = 1'b1; state_d = S_T7; end
          OP_ST: begin Gra = 1'b1; R_out = 1'b1; MDR_rd = 1'b1; state_d = S_T7; end
          OP_BR: begin Zlo_out = 1'b1; PC_rd = con; end
          default: ;
        endcase
      end

      S_T7: begin
        state_d = S_T0;
        case (opcode)
          OP_LD:   begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   Write = 1'b1;
          default: ;
        endcase
      end

      S_HALT: begin
        halted = 1'b1;
        op_sel = 5'b00000;
      end

      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit: each instruction is expanded
// by a reference microprogram table into its expected per-cycle strobe words.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr, run, con, calc_finished;
  logic [31:0] ir;
  logic        dp_clr, R_out, MDR_out, PC_out, Zlo_out, Zhi_out, HI_out, LO_out;
  logic        In_out, C_out, Rin, MDR_rd, MAR_rd, HI_rd, LO_rd, Zhi_rd, Zlo_rd;
  logic        PC_rd, Out_rd, Y_rd, IR_rd, IncPC, Read, Write, Gra, Grb, Grc;
  logic        BAout, CONin, reset_div, halted, illegal;
  logic [4:0]  op_sel;

  control_unit dut (
    .clk(clk), .clr(clr), .run(run), .ir(ir), .con(con),
    .calc_finished(calc_finished), .dp_clr(dp_clr), .op_sel(op_sel),
    .R_out(R_out), .MDR_out(MDR_out), .PC_out(PC_out), .Zlo_out(Zlo_out),
    .Zhi_out(Zhi_out), .HI_out(HI_out), .LO_out(LO_out), .In_out(In_out),
    .C_out(C_out), .Rin(Rin), .MDR_rd(MDR_rd), .MAR_rd(MAR_rd), .HI_rd(HI_rd),
    .LO_rd(LO_rd), .Zhi_rd(Zhi_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd),
    .Out_rd(Out_rd), .Y_rd(Y_rd), .IR_rd(IR_rd), .IncPC(IncPC), .Read(Read),
    .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout),
    .CONin(CONin), .reset_div(reset_div), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] F_DPCLR   = 32'h1 << 0;
  localparam logic [31:0] F_ROUT    = 32'h1 << 1;
  localparam logic [31:0] F_MDROUT  = 32'h1 << 2;
  localparam logic [31:0] F_PCOUT   = 32'h1 << 3;
  localparam logic [31:0] F_ZLOOUT  = 32'h1 << 4;
  localparam logic [31:0] F_ZHIOUT  = 32'h1 << 5;
  localparam logic [31:0] F_HIOUT   = 32'h1 << 6;
  localparam logic [31:0] F_LOOUT   = 32'h1 << 7;
  localparam logic [31:0] F_INOUT   = 32'h1 << 8;
  localparam logic [31:0] F_COUT    = 32'h1 << 9;
  localparam logic [31:0] F_RIN     = 32'h1 << 10;
  localparam logic [31:0] F_MDRRD   = 32'h1 << 11;
  localparam logic [31:0] F_MARRD   = 32'h1 << 12;
  localparam logic [31:0] F_HIRD    = 32'h1 << 13;
  localparam logic [31:0] F_LORD    = 32'h1 << 14;
  localparam logic [31:0] F_ZHIRD   = 32'h1 << 15;
  localparam logic [31:0] F_ZLORD   = 32'h1 << 16;
  localparam logic [31:0] F_PCRD    = 32'h1 << 17;
  localparam logic [31:0] F_OUTRD   = 32'h1 << 18;
  localparam logic [31:0] F_YRD     = 32'h1 << 19;
  localparam logic [31:0] F_IRRD    = 32'h1 << 20;
  localparam logic [31:0] F_INCPC   = 32'h1 << 21;
  localparam logic [31:0] F_READ    = 32'h1 << 22;
  localparam logic [31:0] F_WRITE   = 32'h1 << 23;
  localparam logic [31:0] F_GRA     = 32'h1 << 24;
  localparam logic [31:0] F_GRB     = 32'h1 << 25;
  localparam logic [31:0] F_GRC     = 32'h1 << 26;
  localparam logic [31:0] F_BAOUT   = 32'h1 << 27;
  localparam logic [31:0] F_CONIN   = 32'h1 << 28;
  localparam logic [31:0] F_RSTDIV  = 32'h1 << 29;
  localparam logic [31:0] F_HALTED  = 32'h1 << 30;
  localparam logic [31:0] F_ILLEGAL = 32'h1 << 31;
  localparam logic [4:0]  ADD       = 5'b00011;

  logic [36:0] obs;
  assign obs = {op_sel, illegal, halted, reset_div, CONin, BAout, Grc, Grb, Gra,
                Write, Read, IncPC, IR_rd, Y_rd, Out_rd, PC_rd, Zlo_rd, Zhi_rd,
                LO_rd, HI_rd, MAR_rd, MDR_rd, Rin, C_out, In_out, LO_out, HI_out,
                Zhi_out, Zlo_out, PC_out, MDR_out, R_out, dp_clr};

  int n_checks = 0;
  int n_errors = 0;

  // Expected strobe word plus the calc_finished / con values to apply, per cycle.
  logic [36:0] exp_q[$];
  logic        cf_q[$];
  logic        cn_q[$];

  task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input string tag, input logic [36:0] exp);
    @(negedge clk);
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic [4:0] op, input logic [31:0] fl);
    exp_q.push_back({op, fl});
    cf_q.push_back(1'($urandom_range(0, 1)));
    cn_q.push_back(1'($urandom_range(0, 1)));
  endfunction

  // Microprogram table: the step list each opcode is expected to produce.
  function automatic void plan(input logic [4:0] op, input logic con_v, input int w);
    exp_q.delete(); cf_q.delete(); cn_q.delete();
    push(ADD, F_PCOUT | F_MARRD | F_INCPC);
    push(ADD, F_READ | F_MDRRD);
    push(ADD, F_MDROUT | F_IRRD);
    if (op >= 5'd3 && op <= 5'd14) begin
      push(ADD, F_GRB | F_ROUT | F_YRD);
      push(op,  F_GRC | F_ROUT | F_ZLORD);
      push(ADD, F_ZLOOUT | F_GRA | F_RIN);
    end else if (op == 5'd15) begin
      push(ADD, F_GRA | F_ROUT | F_YRD);
      push(op,  F_GRB | F_ROUT | F_ZHIRD | F_ZLORD);
      push(ADD, F_ZLOOUT | F_LORD);
      push(ADD, F_ZHIOUT | F_HIRD);
`ifdef CU_DIV_EN
    end else if (op == 5'd16) begin
      push(ADD, F_GRA | F_ROUT | F_YRD);
      push(op,  F_GRB | F_ROUT | F_RSTDIV);
      for (int i = 0; i < w; i++) begin
        push(op, F_GRB | F_ROUT);
        cf_q[cf_q.size() - 1] = 1'b0;
      end
      push(op, F_GRB | F_ROUT | F_ZHIRD | F_ZLORD);
      cf_q[cf_q.size() - 1] = 1'b1;
      push(ADD, F_ZLOOUT | F_LORD);
      push(ADD, F_ZHIOUT | F_HIRD);
`endif
    end else if (op <= 5'd2) begin
      push(ADD, F_GRB | F_BAOUT | F_YRD);
      push(ADD, F_COUT | F_ZLORD);
      if (op == 5'd1) begin
        push(ADD, F_ZLOOUT | F_GRA | F_RIN);
      end else begin
        push(ADD, F_ZLOOUT | F_MARRD);
        if (op == 5'd0) begin
          push(ADD, F_READ | F_MDRRD);
          push(ADD, F_MDROUT | F_GRA | F_RIN);
        end else begin
          push(ADD, F_GRA | F_ROUT | F_MDRRD);
          push(ADD, F_WRITE);
        end
      end
    end else if (op == 5'd18) begin
      push(ADD, F_GRA | F_ROUT | F_CONIN);
      push(ADD, F_PCOUT | F_YRD);
      push(ADD, F_COUT | F_ZLORD);
      push(ADD, F_ZLOOUT | (con_v ? F_PCRD : 32'h0));
      cn_q[cn_q.size() - 1] = con_v;
    end else if (op == 5'd22) push(ADD, F_INOUT | F_GRA | F_RIN);
    else if (op == 5'd23)     push(ADD, F_GRA | F_ROUT | F_OUTRD);
    else if (op == 5'd24)     push(ADD, F_HIOUT | F_GRA | F_RIN);
    else if (op == 5'd25)     push(ADD, F_LOOUT | F_GRA | F_RIN);
    else if (op == 5'd26 || op == 5'd27) push(ADD, 32'h0);
    else                      push(ADD, F_ILLEGAL);
  endfunction

  task automatic run_instr(input logic [31:0] ir_v, input logic con_v, input int w,
                           input string tag);
    plan(ir_v[31:27], con_v, w);
    ir = ir_v;
    for (int i = 0; i < exp_q.size(); i++) begin
      run           = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      calc_finished = cf_q[i];
      con           = cn_q[i];
      cycle($sformatf("%s.c%0d", tag, i), exp_q[i]);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      run           = 1'b0;
      calc_finished = 1'($urandom_range(0, 1));
      con           = 1'($urandom_range(0, 1));
      cycle($sformatf("%s.%0d", tag, i), {5'b0, 32'h0});
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    return {op, 27'($urandom)};
  endfunction

  initial begin
    logic [4:0] op;
    clr = 1'b0; run = 1'b1; con = 1'b0; calc_finished = 1'b0; ir = 32'h0;

    // Reset held two edges, then one RST cycle after release.
    @(posedge clk); #1;
    cycle("rst_hold", {5'b0, F_DPCLR});
    clr = 1'b1;
    cycle("rst_release", {5'b0, F_DPCLR});
    idle(3, "t0_idle");

    run_instr(32'h1800_0000, 1'b0, 0, "add");
    run_instr(mk_ir(5'b10000), 1'b0, 5, "div_w5");
    run_instr(mk_ir(5'b10000), 1'b0, 0, "div_w0");
    run_instr(mk_ir(5'b10010), 1'b0, 0, "br_c0");
    run_instr(mk_ir(5'b10010), 1'b1, 0, "br_c1");
    run_instr(mk_ir(5'b00010), 1'b0, 0, "st");
    idle(2, "park");
    run_instr(mk_ir(5'b00000), 1'b0, 0, "ld");
    run_instr(mk_ir(5'b00001), 1'b0, 0, "ldi");
    run_instr(mk_ir(5'b01111), 1'b0, 0, "mul");
    run_instr(mk_ir(5'b11111), 1'b0, 0, "illegal_op");

    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr(mk_ir(op), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                $sformatf("rnd%0d_op%0d", k, op));
    end

    // Reset asserted during ld T6 must win over the T6 -> T7 transition.
    plan(5'b00000, 1'b0, 0);
    ir = mk_ir(5'b00000);
    for (int i = 0; i < 7; i++) begin
      run = (i == 0) ? 1'b1 : 1'b0;
      calc_finished = cf_q[i];
      con = cn_q[i];
      if (i == 6) clr = 1'b0;
      cycle($sformatf("ld_abort.c%0d", i), exp_q[i]);
    end
    clr = 1'b1;
    cycle("ld_abort.rst", {5'b0, F_DPCLR});
    run_instr(32'h1800_0000, 1'b0, 0, "after_abort");

    run_instr(mk_ir(5'b11011), 1'b0, 0, "halt");
    for (int i = 0; i < 10; i++) begin
      run = 1'($urandom_range(0, 1));
      calc_finished = 1'($urandom_range(0, 1));
      con = 1'($urandom_range(0, 1));
      cycle($sformatf("halted.%0d", i), {5'b0, F_HALTED});
    end
    clr = 1'b0;
    cycle("halt_clr", {5'b0, F_HALTED});
    clr = 1'b1;
    cycle("halt_rst", {5'b0, F_DPCLR});
    run_instr(mk_ir(5'b10111), 1'b0, 0, "after_halt");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
